// File: rtl/library_checker_if.sv
// Stimulus, cell-response and status bundle between the library bench and its checker.
// The bench side uses the master modport; the checker consumes through slave.
interface library_checker_if #(
  parameter int CNT_W = 16
);
  logic             iStart;
  logic             iA, iB, iSel, iEnb, iD, iDutClr, iDutPre;
  logic             iNand, iNor, iNot, iMux, iQp, iQn;
  logic             oBusy, oDone, oPass, oErrFlag;
  logic [CNT_W-1:0] oVecCnt, oErrCnt, oFirstErrIdx;
  logic [5:0]       oFirstErrMask;

  modport master (
    output iStart, iA, iB, iSel, iEnb, iD, iDutClr, iDutPre,
    output iNand, iNor, iNot, iMux, iQp, iQn,
    input  oBusy, oDone, oPass, oErrFlag, oVecCnt, oErrCnt, oFirstErrIdx, oFirstErrMask
  );

  modport slave (
    input  iStart, iA, iB, iSel, iEnb, iD, iDutClr, iDutPre,
    input  iNand, iNor, iNot, iMux, iQp, iQn,
    output oBusy, oDone, oPass, oErrFlag, oVecCnt, oErrCnt, oFirstErrIdx, oFirstErrMask
  );
endinterface

// File: rtl/library_checker.sv
// Checks nand/nor/not/mux/ffd responses against a golden model, one vector per clock in RUN.
// Status is registered: a vector sampled at edge k shows in the counters after edge k; no backpressure.
module library_checker #(
  parameter int CNT_W   = 16,
  parameter int NUM_VEC = 64
) (
  input logic             iClk,
  input logic             iClr,
  library_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC - 1);

  state_t           state_q;
  logic             busy_q, done_q, pass_q, err_flag_q;
  logic             d_hist_q, hist_vld_q;
  logic [CNT_W-1:0] vec_cnt_q, err_cnt_q, first_idx_q;
  logic [5:0]       first_mask_q;

  logic             exp_qp;
  logic [5:0]       mask_d;
  logic [CNT_W-1:0] vec_cnt_d, err_cnt_d;

  // Case inequality so an X or Z on a checked output is flagged as a mismatch.
  always_comb begin
    exp_qp = d_hist_q;
    if (!bus.iDutClr) exp_qp = 1'b0;
    else if (!bus.iDutPre) exp_qp = 1'b1;
    mask_d[0] = bus.iNand !== ~(bus.iA & bus.iB);
    mask_d[1] = bus.iNor  !== ~(bus.iA | bus.iB);
    mask_d[2] = bus.iNot  !== ~bus.iA;
    mask_d[3] = bus.iMux  !== (bus.iEnb & (bus.iSel ? bus.iB : bus.iA));
    mask_d[4] = bus.iQp   !== exp_qp;
    mask_d[5] = bus.iQn   !== ~exp_qp;
    // With no captured D yet and no async control active, Q is unknowable.
    if (!hist_vld_q && bus.iDutClr && bus.iDutPre) mask_d[5:4] = 2'b00;
  end

  assign vec_cnt_d = vec_cnt_q + CNT_W'(1);
  assign err_cnt_d = ((|mask_d) && (err_cnt_q != CNT_MAX)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_flag_q   <= 1'b0;
      d_hist_q     <= 1'b0;
      hist_vld_q   <= 1'b0;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_mask_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.iStart) begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_flag_q   <= 1'b0;
            hist_vld_q   <= 1'b0;
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_mask_q <= '0;
          end
        end
        RUN: begin
          vec_cnt_q  <= vec_cnt_d;
          err_cnt_q  <= err_cnt_d;
          d_hist_q   <= bus.iD;
          hist_vld_q <= 1'b1;
          if (|mask_d) begin
            err_flag_q <= 1'b1;
            if (!err_flag_q) begin
              first_idx_q  <= vec_cnt_q;
              first_mask_q <= mask_d;
            end
          end
          if (vec_cnt_q == LAST_VEC) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oBusy         = busy_q;
  assign bus.oDone         = done_q;
  assign bus.oPass         = pass_q;
  assign bus.oErrFlag      = err_flag_q;
  assign bus.oVecCnt       = vec_cnt_q;
  assign bus.oErrCnt       = err_cnt_q;
  assign bus.oFirstErrIdx  = first_idx_q;
  assign bus.oFirstErrMask = first_mask_q;

endmodule
